xfer_req_arbiter: RTL and testbench

XFER_REQ_ARBITER -- requirements
Module: xfer_req_arbiter

---
 rtl/xfer_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_xfer_req_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/xfer_req_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ 4-phase transfer requests onto a
// single 4-phase request/acknowledge channel toward the descriptor handler.
module xfer_req_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int XFER_PARAMS_WIDTH = 79,
    parameter int IDX_WIDTH         = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ*XFER_PARAMS_WIDTH-1:0] req_params_i,
    input  logic [NUM_REQ-1:0]                   req_i,
    output logic [NUM_REQ-1:0]                   ack_o,
    output logic [XFER_PARAMS_WIDTH-1:0]         m_xfer_params_o,
    output logic                                 m_xfer_req_o,
    input  logic                                 m_xfer_ack_i,
    output logic [IDX_WIDTH-1:0]                 grant_id_o,
    output logic                                 busy_o,
    output logic [15:0]                          grant_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                       r_state, w_state_nxt;
    logic [NUM_REQ-1:0]           r_ack, w_ack_nxt;
    logic                         r_m_req, w_m_req_nxt;
    logic [XFER_PARAMS_WIDTH-1:0] r_params, w_params_nxt;
    logic [IDX_WIDTH-1:0]         r_grant_id, w_grant_id_nxt;
    logic [IDX_WIDTH-1:0]         r_last_winner, w_last_winner_nxt;
    logic [15:0]                  r_count, w_count_nxt;
    logic                         r_busy;

    logic [XFER_PARAMS_WIDTH-1:0] w_slice [NUM_REQ];
    logic                         w_found;
    logic [IDX_WIDTH-1:0]         w_win;
    logic [IDX_WIDTH-1:0]         w_idx;
    logic [NUM_REQ-1:0]           w_grant_onehot;

    // Split the flat parameter bus into one word per requester.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_slice[k] = req_params_i[k*XFER_PARAMS_WIDTH +: XFER_PARAMS_WIDTH];
        end
    end

    // Round-robin search: first active request at or after last_winner+1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx   = IDX_WIDTH'((int'(r_last_winner) + 1 + i) % NUM_REQ);
            w_win   = (!w_found && req_i[w_idx]) ? w_idx : w_win;
            w_found = w_found | req_i[w_idx];
        end
    end

    assign w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_ack_nxt         = r_ack;
        w_m_req_nxt       = r_m_req;
        w_params_nxt      = r_params;
        w_grant_id_nxt    = r_grant_id;
        w_last_winner_nxt = r_last_winner;
        w_count_nxt       = r_count;
        case (r_state)
            ST_IDLE: begin
                // A stray downstream ack here is deliberately ignored.
                if (w_found) begin
                    w_grant_id_nxt = w_win;
                    w_params_nxt   = w_slice[w_win];
                    w_m_req_nxt    = 1'b1;
                    w_state_nxt    = ST_ISSUE;
                end else begin
                    w_ack_nxt   = '0;
                    w_m_req_nxt = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (m_xfer_ack_i) begin
                    w_m_req_nxt = 1'b0;
                    w_ack_nxt   = w_grant_onehot;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_m_req_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!m_xfer_ack_i && !req_i[r_grant_id]) begin
                    w_ack_nxt         = '0;
                    w_last_winner_nxt = r_grant_id;
                    w_count_nxt       = r_count + 16'd1;
                    w_state_nxt       = ST_IDLE;
                end else begin
                    w_ack_nxt = w_grant_onehot;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ack_nxt   = '0;
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_ack         <= '0;
            r_m_req       <= 1'b0;
            r_params      <= '0;
            r_grant_id    <= '0;
            r_last_winner <= IDX_WIDTH'(NUM_REQ - 1);
            r_count       <= 16'd0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ack         <= w_ack_nxt;
            r_m_req       <= w_m_req_nxt;
            r_params      <= w_params_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_count       <= w_count_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    assign ack_o           = r_ack;
    assign m_xfer_req_o    = r_m_req;
    assign m_xfer_params_o = r_params;
    assign grant_id_o      = r_grant_id;
    assign busy_o          = r_busy;
    assign grant_count_o   = r_count;

endmodule

// File: tb/tb_xfer_req_arbiter.sv
// Directed self-checking bench for xfer_req_arbiter (default 4 requesters).
module tb_xfer_req_arbiter;

    localparam int N  = 4;
    localparam int W  = 79;
    localparam int IW = 2;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N*W-1:0] req_params_i;
    logic [N-1:0]   req_i;
    logic [N-1:0]   ack_o;
    logic [W-1:0]   m_xfer_params_o;
    logic           m_xfer_req_o;
    logic           m_xfer_ack_i;
    logic [IW-1:0]  grant_id_o;
    logic           busy_o;
    logic [15:0]    grant_count_o;

    int n_checks = 0;
    int n_errors = 0;

    xfer_req_arbiter #(.NUM_REQ(N), .XFER_PARAMS_WIDTH(W), .IDX_WIDTH(IW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_params_i    (req_params_i),
        .req_i           (req_i),
        .ack_o           (ack_o),
        .m_xfer_params_o (m_xfer_params_o),
        .m_xfer_req_o    (m_xfer_req_o),
        .m_xfer_ack_i    (m_xfer_ack_i),
        .grant_id_o      (grant_id_o),
        .busy_o          (busy_o),
        .grant_count_o   (grant_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] param_of(input int k);
        logic [W-1:0] p;
        p = 79'h1_ABCD + (W'(k) << 24);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full handshake with requester id; hold = cycles in Issue before the ack.
    task automatic grant_cycle(input int id, input int hold, input logic rearm, input logic [15:0] cnt_after);
        tick();
        check("gnt_req", 128'(m_xfer_req_o), 128'd1);
        check("gnt_id", 128'(grant_id_o), 128'(id));
        check("gnt_params", 128'(m_xfer_params_o), 128'(param_of(id)));
        check("gnt_busy", 128'(busy_o), 128'd1);
        check("gnt_noack", 128'(ack_o), 128'd0);
        repeat (hold) begin
            tick();
            check("hold_req", 128'(m_xfer_req_o), 128'd1);
        end
        m_xfer_ack_i = 1'b1;
        tick();
        check("rel_ack", 128'(ack_o), 128'(4'b0001 << id));
        check("rel_mreq", 128'(m_xfer_req_o), 128'd0);
        m_xfer_ack_i = 1'b0;
        req_i[id]    = 1'b0;
        tick();
        check("done_ack", 128'(ack_o), 128'd0);
        check("done_busy", 128'(busy_o), 128'd0);
        check("done_cnt", 128'(grant_count_o), 128'(cnt_after));
        req_i[id] = rearm;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = '0;
        m_xfer_ack_i = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) req_params_i[k*W +: W] = param_of(k);
        do_reset();
        check("rst_ack", 128'(ack_o), 128'd0);
        check("rst_mreq", 128'(m_xfer_req_o), 128'd0);
        check("rst_params", 128'(m_xfer_params_o), 128'd0);
        check("rst_gid", 128'(grant_id_o), 128'd0);
        check("rst_cnt", 128'(grant_count_o), 128'd0);
        check("rst_busy", 128'(busy_o), 128'd0);

        // single requester 0 with params 1_ABCD
        req_i = 4'b0001;
        grant_cycle(0, 0, 1'b0, 16'd1);

        // all four held: 0,1,2,3,0
        do_reset();
        req_i = 4'b1111;
        grant_cycle(0, 1, 1'b1, 16'd1);
        grant_cycle(1, 1, 1'b1, 16'd2);
        grant_cycle(2, 1, 1'b1, 16'd3);
        grant_cycle(3, 1, 1'b1, 16'd4);
        grant_cycle(0, 1, 1'b1, 16'd5);

        // last winner 0, requesters 1 and 2 held: 1,2,1
        req_i = 4'b0110;
        grant_cycle(1, 0, 1'b1, 16'd6);
        grant_cycle(2, 0, 1'b1, 16'd7);
        grant_cycle(1, 0, 1'b1, 16'd8);

        // requester 3 drops right after grant, downstream ack delayed 5 cycles
        req_i = 4'b1000;
        tick();
        check("r3_gid", 128'(grant_id_o), 128'd3);
        check("r3_req", 128'(m_xfer_req_o), 128'd1);
        req_i = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("r3_hold", 128'(m_xfer_req_o), 128'd1);
            check("r3_pstable", 128'(m_xfer_params_o), 128'(param_of(3)));
        end
        m_xfer_ack_i = 1'b1;
        tick();
        check("r3_ack", 128'(ack_o), 128'h8);
        m_xfer_ack_i = 1'b0;
        tick();
        check("r3_ackfall", 128'(ack_o), 128'd0);
        check("r3_idle", 128'(busy_o), 128'd0);
        check("r3_cnt", 128'(grant_count_o), 128'd9);

        // stray downstream ack in Idle is ignored
        m_xfer_ack_i = 1'b1;
        tick();
        tick();
        check("idle_ack_busy", 128'(busy_o), 128'd0);
        check("idle_ack_mreq", 128'(m_xfer_req_o), 128'd0);
        check("idle_ack_ack", 128'(ack_o), 128'd0);
        m_xfer_ack_i = 1'b0;

        // asynchronous reset while in Release
        req_i = 4'b0100;
        tick();
        check("ar_gid", 128'(grant_id_o), 128'd2);
        m_xfer_ack_i = 1'b1;
        tick();
        check("ar_relack", 128'(ack_o), 128'h4);
        rst_ni = 1'b0;
        #1;
        check("ar_ack", 128'(ack_o), 128'd0);
        check("ar_mreq", 128'(m_xfer_req_o), 128'd0);
        check("ar_busy", 128'(busy_o), 128'd0);
        check("ar_cnt", 128'(grant_count_o), 128'd0);
        m_xfer_ack_i = 1'b0;
        req_i = 4'b0101;
        tick();
        rst_ni = 1'b1;
        grant_cycle(0, 0, 1'b0, 16'd1);
        req_i = 4'b0000;
        tick();

        // counter wrap via backdoor preload
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        #1;
        check("wrap_pre", 128'(grant_count_o), 128'hFFFF);
        req_i = 4'b0010;
        grant_cycle(1, 0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
